// File: rtl/escalonador_calculadora_pkg.sv
// Shared definitions for the calculator scheduler: FSM encodings and
// calculator operation codes (defaults and the codes benches exercise).
package escalonador_calculadora_pkg;

    // Scheduler FSM encodings
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    // Calculator operation codes
    localparam logic [2:0] NOP_CODE_DEF = 3'b000;
    localparam logic [2:0] CLR_CODE_DEF = 3'b001;
    localparam logic [2:0] ADD_CODE     = 3'b010;
    localparam logic [2:0] SUB_CODE     = 3'b011;

endpackage

// File: rtl/escalonador_calculadora_arbitro_rr2.sv
// Two-way combinational grant: the requester holding priority wins when it
// is valid, otherwise the other one is granted if it is valid.
module arbitro_rr2 (
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic grant_valid,
    output logic grant_id
);

    logic prio_valid;

    assign prio_valid  = prio ? valid1 : valid0;
    assign grant_valid = valid0 | valid1;
    assign grant_id    = prio_valid ? prio : ~prio;

endmodule

// File: rtl/escalonador_calculadora.sv
// Round-robin scheduler that locks one shared accumulator calculator to a
// single requester for a whole command burst, clears it first, collects the
// final result after a fixed latency and returns it on the owner's response.
module escalonador_calculadora
    import escalonador_calculadora_pkg::*;
#(
    parameter int         RESULT_LAT = 2,
    parameter logic [2:0] NOP_CODE   = NOP_CODE_DEF,
    parameter logic [2:0] CLR_CODE   = CLR_CODE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_codigo,
    input  logic [7:0] req0_entrada,
    input  logic       req0_last,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_codigo,
    input  logic [7:0] req1_entrada,
    input  logic       req1_last,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_dado,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_dado,
    output logic [2:0] calc_codigo,
    output logic [7:0] calc_entrada,
    input  logic [7:0] calc_saida
);

    localparam int CW = $clog2(RESULT_LAT + 1);

    logic [2:0]    state;
    logic          owner;
    logic          prio;
    logic [CW-1:0] cnt;
    logic [7:0]    dado;

    logic          grant_valid;
    logic          grant_id;

    // Owner-side views of the request/response channels
    logic          cur_valid;
    logic [2:0]    cur_codigo;
    logic [7:0]    cur_entrada;
    logic          cur_last;
    logic          cur_rsp_ready;
    logic          handshake;

    arbitro_rr2 u_arbitro (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .prio        (prio),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign cur_valid     = owner ? req1_valid   : req0_valid;
    assign cur_codigo    = owner ? req1_codigo  : req0_codigo;
    assign cur_entrada   = owner ? req1_entrada : req0_entrada;
    assign cur_last      = owner ? req1_last    : req0_last;
    assign cur_rsp_ready = owner ? rsp1_ready   : rsp0_ready;

    // Ready depends only on state/owner so requesters may wait on it freely
    assign req0_ready = (state == S_ISSUE) && !owner;
    assign req1_ready = (state == S_ISSUE) &&  owner;
    assign handshake  = (state == S_ISSUE) && cur_valid;

    // Non-owner response is forced to zero, not just invalid
    assign rsp0_valid = (state == S_RESP) && !owner;
    assign rsp1_valid = (state == S_RESP) &&  owner;
    assign rsp0_dado  = rsp0_valid ? dado : 8'd0;
    assign rsp1_dado  = rsp1_valid ? dado : 8'd0;

    // Scheduler FSM; the calc bus falls back to NOP/0 unless a state drives it
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            owner        <= 1'b0;
            prio         <= 1'b0;
            cnt          <= '0;
            dado         <= 8'd0;
            calc_codigo  <= NOP_CODE;
            calc_entrada <= 8'd0;
        end else begin
            calc_codigo  <= NOP_CODE;
            calc_entrada <= 8'd0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_id;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    calc_codigo <= CLR_CODE;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    // A stalled owner keeps the lock; the bus carries NOPs meanwhile
                    if (handshake) begin
                        calc_codigo  <= cur_codigo;
                        calc_entrada <= cur_entrada;
                        if (cur_last) begin
                            cnt   <= CW'(RESULT_LAT);
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // cnt reaches zero exactly when the last command's result is on calc_saida
                    if (cnt == '0) begin
                        dado  <= calc_saida;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RESP: begin
                    if (cur_rsp_ready) begin
                        prio  <= ~owner;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_calculadora.sv
// Directed bench for the calculator scheduler with a stub accumulator
// calculator whose output trails its input bus by RESULT_LAT cycles.
module tb_escalonador_calculadora;
    import escalonador_calculadora_pkg::*;

    localparam int RESULT_LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req0_last;
    logic [2:0] req0_codigo;
    logic [7:0] req0_entrada;
    logic       req1_valid, req1_ready, req1_last;
    logic [2:0] req1_codigo;
    logic [7:0] req1_entrada;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_dado, rsp1_dado;
    logic [2:0] calc_codigo;
    logic [7:0] calc_entrada, calc_saida;

    int checks = 0;
    int errors = 0;

    escalonador_calculadora #(.RESULT_LAT(RESULT_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_codigo(req0_codigo),
        .req0_entrada(req0_entrada), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_codigo(req1_codigo),
        .req1_entrada(req1_entrada), .req1_last(req1_last),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dado(rsp0_dado),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dado(rsp1_dado),
        .calc_codigo(calc_codigo), .calc_entrada(calc_entrada), .calc_saida(calc_saida)
    );

    always #5 clk = ~clk;

    // Stub calculator: accumulator plus one output stage (total latency 2)
    logic [7:0] acc, saida_q;
    always @(posedge clk) begin
        if (reset) begin
            acc     <= 8'd0;
            saida_q <= 8'd0;
        end else begin
            case (calc_codigo)
                CLR_CODE_DEF: acc <= 8'd0;
                ADD_CODE:     acc <= acc + calc_entrada;
                SUB_CODE:     acc <= acc - calc_entrada;
                default:      acc <= acc;
            endcase
            saida_q <= acc;
        end
    end
    assign calc_saida = saida_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rvld(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic wait_ready(input int p, input string tag);
        int n = 0;
        while (!rdy(p) && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(rdy(p)), 1);
    endtask

    // Wait for the response, check it, then consume it for one cycle
    task automatic get_rsp(input int p, input logic [7:0] exp, input string tag);
        int n = 0;
        while (!rvld(p) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(rvld(p)), 1);
        chk({tag, "_dado"}, (p == 1) ? 32'(rsp1_dado) : 32'(rsp0_dado), 32'(exp));
        chk({tag, "_other"}, 32'(rvld(1 - p)), 0);
        if (p == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic set0(input logic v, input logic [2:0] c, input logic [7:0] e, input logic l);
        req0_valid = v; req0_codigo = c; req0_entrada = e; req0_last = l;
    endtask

    task automatic set1(input logic v, input logic [2:0] c, input logic [7:0] e, input logic l);
        req1_valid = v; req1_codigo = c; req1_entrada = e; req1_last = l;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_codigo"}, 32'(calc_codigo), 32'(NOP_CODE_DEF));
        chk({tag, "_entrada"}, 32'(calc_entrada), 0);
        chk({tag, "_rdy"}, {30'd0, req1_ready, req0_ready}, 0);
        chk({tag, "_rspv"}, {30'd0, rsp1_valid, rsp0_valid}, 0);
        chk({tag, "_dado"}, {16'd0, rsp1_dado, rsp0_dado}, 0);
    endtask

    initial begin
        int who;
        int n;
        reset = 1'b1;
        set0(0, 3'd0, 8'd0, 0);
        set1(0, 3'd0, 8'd0, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        tick(); tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic burst: ADD 5, ADD 7(last) from req0
        set0(1, ADD_CODE, 8'd5, 0);
        tick();                                       // C+1: CLEAR
        chk("b_clear_rdy", 32'(req0_ready), 0);
        tick();                                       // C+2
        chk("b_clr_code", 32'(calc_codigo), 32'(CLR_CODE_DEF));
        chk("b_rdy0", 32'(req0_ready), 1);
        chk("b_rdy1", 32'(req1_ready), 0);
        tick();                                       // C+3: ADD 5 on bus
        chk("b_add5", {calc_codigo, calc_entrada}, {ADD_CODE, 8'd5});
        set0(1, ADD_CODE, 8'd7, 1);
        tick();                                       // H+1
        chk("b_add7", {calc_codigo, calc_entrada}, {ADD_CODE, 8'd7});
        chk("b_wait_rdy", 32'(req0_ready), 0);
        set0(0, 3'd0, 8'd0, 0);
        tick();                                       // H+2
        chk("b_nop", {calc_codigo, calc_entrada}, {NOP_CODE_DEF, 8'd0});
        tick();                                       // H+3
        chk("b_early_rsp", 32'(rsp0_valid), 0);
        tick();                                       // H+4
        chk("b_rsp_h4", 32'(rsp0_valid), 1);
        get_rsp(0, 8'd12, "b_rsp");
        chk("b_idle_rsp", 32'(rsp0_valid), 0);

        // Simultaneous requests after reset: req0 first, then req1 with its own clear
        reset = 1'b1; tick(); reset = 1'b0;
        set0(1, ADD_CODE, 8'd3, 1);
        set1(1, ADD_CODE, 8'd9, 1);
        tick(); tick();
        chk("s_rdy0", 32'(req0_ready), 1);
        chk("s_rdy1", 32'(req1_ready), 0);
        tick();
        set0(0, 3'd0, 8'd0, 0);
        get_rsp(0, 8'd3, "s_rsp0");
        wait_ready(1, "s_wait1");
        chk("s_clr1", 32'(calc_codigo), 32'(CLR_CODE_DEF));
        tick();
        set1(0, 3'd0, 8'd0, 0);
        get_rsp(1, 8'd9, "s_rsp1");

        // Fairness: both always valid, grants must alternate 0,1,0,1
        set0(1, ADD_CODE, 8'd1, 1);
        set1(1, ADD_CODE, 8'd2, 1);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!req0_ready && !req1_ready && n < 20) begin
                tick();
                n++;
            end
            who = req1_ready ? 1 : 0;
            chk("f_grant", 32'(who), 32'(i % 2));
            tick();
            get_rsp(who, (who == 1) ? 8'd2 : 8'd1, "f_rsp");
        end
        set0(0, 3'd0, 8'd0, 0);
        set1(0, 3'd0, 8'd0, 0);

        // Valid gaps mid-burst and 8-bit wrap: 200 + 100 = 44
        set1(1, ADD_CODE, 8'd200, 0);
        wait_ready(1, "g_wait");
        tick();
        chk("g_add200", {calc_codigo, calc_entrada}, {ADD_CODE, 8'd200});
        set1(0, 3'd0, 8'd0, 0);
        tick();
        chk("g_nop1", {calc_codigo, calc_entrada}, {NOP_CODE_DEF, 8'd0});
        tick();
        chk("g_nop2", {calc_codigo, calc_entrada}, {NOP_CODE_DEF, 8'd0});
        chk("g_lock", 32'(req1_ready), 1);
        set1(1, ADD_CODE, 8'd100, 1);
        tick();
        chk("g_add100", {calc_codigo, calc_entrada}, {ADD_CODE, 8'd100});
        set1(0, 3'd0, 8'd0, 0);
        get_rsp(1, 8'd44, "g_rsp");

        // Response backpressure on req0 while req1 waits
        set0(1, ADD_CODE, 8'd6, 1);
        set1(1, ADD_CODE, 8'd8, 1);
        wait_ready(0, "p_wait0");
        chk("p_rdy1", 32'(req1_ready), 0);
        tick();
        set0(0, 3'd0, 8'd0, 0);
        n = 0;
        while (!rsp0_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("p_hold_v", 32'(rsp0_valid), 1);
            chk("p_hold_d", 32'(rsp0_dado), 6);
            chk("p_hold_r1", 32'(req1_ready), 0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();                                       // R+1
        rsp0_ready = 1'b0;
        chk("p_r1_rdy", 32'(req1_ready), 0);
        tick();                                       // R+2
        chk("p_r2_rdy", 32'(req1_ready), 0);
        tick();                                       // R+3
        chk("p_r3_rdy", 32'(req1_ready), 1);
        chk("p_r3_clr", 32'(calc_codigo), 32'(CLR_CODE_DEF));
        tick();
        set1(0, 3'd0, 8'd0, 0);
        get_rsp(1, 8'd8, "p_rsp1");

        // Reset in ISSUE after ADD 4: burst dropped, no response
        set0(1, ADD_CODE, 8'd4, 0);
        wait_ready(0, "r_wait");
        tick();
        chk("r_add4", {calc_codigo, calc_entrada}, {ADD_CODE, 8'd4});
        reset = 1'b1;
        set0(0, 3'd0, 8'd0, 0);
        tick();
        chk_reset_outputs("r_abort");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("r_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
            tick();
        end
        set0(1, ADD_CODE, 8'd1, 1);
        wait_ready(0, "r_new_wait");
        tick();
        set0(0, 3'd0, 8'd0, 0);
        get_rsp(0, 8'd1, "r_new_rsp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
